// File: rtl/sprite_layer.sv
// sprite_layer: pipelined, scaled, optionally mirrored and animated sprite
// renderer. It composites the sprite over the incoming background colour,
// and instances chain layer-on-layer along the VGA pixel path.
module sprite_layer #(
  parameter int IMG_W           = 32,
  parameter int IMG_H           = 32,
  parameter int SCALE_LOG2      = 1,
  parameter int NUM_FRAMES      = 4,
  parameter int FRAME_HOLD      = 8,
  parameter int ROM_LATENCY     = 1,
  parameter int PAL_BITS        = 4,
  parameter int TRANSPARENT_IDX = 0,
  localparam int AW             = $clog2(IMG_W * IMG_H * NUM_FRAMES),
  localparam int FW             = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                blank,
  input  logic                vsync_pulse,
  input  logic                enable,
  input  logic                anim_en,
  input  logic                flip_x,
  input  logic [9:0]          pos_x,
  input  logic [9:0]          pos_y,
  input  logic [3:0]          bg_red,
  input  logic [3:0]          bg_green,
  input  logic [3:0]          bg_blue,
  output logic [AW-1:0]       rom_address,
  input  logic [PAL_BITS-1:0] rom_q,
  output logic [PAL_BITS-1:0] pal_index,
  input  logic [3:0]          pal_red,
  input  logic [3:0]          pal_green,
  input  logic [3:0]          pal_blue,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic [FW-1:0]       frame_idx
);

  localparam int LXW = $clog2(IMG_W);
  localparam int LYW = $clog2(IMG_H);
  localparam int HW  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [10:0] SW = 11'(IMG_W << SCALE_LOG2);
  localparam logic [10:0] SH = 11'(IMG_H << SCALE_LOG2);

  logic [10:0]   x_ext, y_ext, x_end, y_end, dx, dy;
  logic          hit;
  logic [LXW-1:0] lx;
  logic [LYW-1:0] ly;

  logic [ROM_LATENCY-1:0] hit_pipe;
  logic [ROM_LATENCY-1:0] blank_pipe;
  logic [11:0]            bg_pipe [ROM_LATENCY];
  logic [11:0]            pix_next;
  logic [HW-1:0]          hold_cnt;

  // Hit test and texel address; 11-bit bounds so a sprite near the right or
  // bottom edge is clipped rather than wrapping to column/row 0.
  always_comb begin
    x_ext = {1'b0, DrawX};
    y_ext = {1'b0, DrawY};
    x_end = {1'b0, pos_x} + SW;
    y_end = {1'b0, pos_y} + SH;
    dx    = x_ext - {1'b0, pos_x};
    dy    = y_ext - {1'b0, pos_y};
    hit   = enable && (DrawX >= pos_x) && (x_ext < x_end)
                   && (DrawY >= pos_y) && (y_ext < y_end);
    lx    = LXW'(dx >> SCALE_LOG2);
    // IMG_W is a power of two, so IMG_W-1-lx is simply the bitwise inverse.
    if (flip_x) lx = ~lx;
    ly    = LYW'(dy >> SCALE_LOG2);
    rom_address = hit ? ((AW'(frame_idx) << (LXW + LYW)) | AW'({ly, lx})) : '0;
  end

  assign pal_index = rom_q;

  // Delay hit, blank and background so they line up with the ROM data.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_pipe   <= '0;
      blank_pipe <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) bg_pipe[i] <= '0;
    end else begin
      hit_pipe[0]   <= hit;
      blank_pipe[0] <= blank;
      bg_pipe[0]    <= {bg_red, bg_green, bg_blue};
      for (int i = 1; i < ROM_LATENCY; i++) begin
        hit_pipe[i]   <= hit_pipe[i-1];
        blank_pipe[i] <= blank_pipe[i-1];
        bg_pipe[i]    <= bg_pipe[i-1];
      end
    end
  end

  // Pick blanked black, opaque sprite colour, or the background underneath.
  always_comb begin
    pix_next = bg_pipe[ROM_LATENCY-1];
    if (!blank_pipe[ROM_LATENCY-1])
      pix_next = '0;
    else if (hit_pipe[ROM_LATENCY-1] && (rom_q != PAL_BITS'(TRANSPARENT_IDX)))
      pix_next = {pal_red, pal_green, pal_blue};
  end

  // Registered pixel output.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      {red, green, blue} <= pix_next;
    end
  end

  // Animation: advance one frame every FRAME_HOLD vsync pulses while enabled;
  // changing only on vsync keeps every visible frame tear-free.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt  <= '0;
      frame_idx <= '0;
    end else if (vsync_pulse && anim_en) begin
      if (hold_cnt == HW'(FRAME_HOLD - 1)) begin
        hold_cnt <= '0;
        if (frame_idx == FW'(NUM_FRAMES - 1)) frame_idx <= '0;
        else                                   frame_idx <= frame_idx + FW'(1);
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sprite_layer.sv
// tb_sprite_layer: drives a ROM_LATENCY=1 and a ROM_LATENCY=3 sprite_layer
// with identical directed stimulus and checks both against a pixel-level
// model of the sprite rules, plus literal expectations at key pixels.
module tb_sprite_layer;

  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int SCALE = 2;
  localparam int NFR   = 4;
  localparam int HOLD  = 8;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic       reset_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, pos_x = 10'd100, pos_y = 10'd50;
  logic       blank = 1'b0, vsync_pulse = 1'b0, enable = 1'b1;
  logic       anim_en = 1'b0, flip_x = 1'b0;
  logic [3:0] bg_red = 4'h0, bg_green = 4'h0, bg_blue = 4'h8;

  logic [11:0] rom_address1, rom_address3;
  logic [3:0]  rom_q1, rom_q3, q3_a, q3_b;
  logic [3:0]  pal_index1, pal_index3;
  logic [3:0]  pal_red1, pal_green1, pal_blue1, pal_red3, pal_green3, pal_blue3;
  logic [3:0]  red1, green1, blue1, red3, green3, blue3;
  logic [1:0]  frame_idx1, frame_idx3;

  logic [3:0]  rom_mem [4096];

  int   checks = 0;
  int   errors = 0;
  logic check_en = 1'b0;

  // Palette: index 0 is deliberately visible so a transparency bug shows.
  function automatic logic [11:0] pal_color(input logic [3:0] idx);
    case (idx)
      4'd0:    return 12'h0A0;
      4'd5:    return 12'hF00;
      4'd7:    return 12'h0F0;
      default: return {idx, idx, idx};
    endcase
  endfunction

  assign {pal_red1, pal_green1, pal_blue1} = pal_color(pal_index1);
  assign {pal_red3, pal_green3, pal_blue3} = pal_color(pal_index3);

  sprite_layer #(.ROM_LATENCY(1)) u_dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .vsync_pulse(vsync_pulse), .enable(enable), .anim_en(anim_en),
    .flip_x(flip_x), .pos_x(pos_x), .pos_y(pos_y),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_address(rom_address1), .rom_q(rom_q1), .pal_index(pal_index1),
    .pal_red(pal_red1), .pal_green(pal_green1), .pal_blue(pal_blue1),
    .red(red1), .green(green1), .blue(blue1), .frame_idx(frame_idx1));

  sprite_layer #(.ROM_LATENCY(3)) u_dut3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .vsync_pulse(vsync_pulse), .enable(enable), .anim_en(anim_en),
    .flip_x(flip_x), .pos_x(pos_x), .pos_y(pos_y),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_address(rom_address3), .rom_q(rom_q3), .pal_index(pal_index3),
    .pal_red(pal_red3), .pal_green(pal_green3), .pal_blue(pal_blue3),
    .red(red3), .green(green3), .blue(blue3), .frame_idx(frame_idx3));

  // Synchronous sprite ROMs with 1 and 3 cycles of latency.
  always @(posedge vga_clk) begin
    rom_q1 <= rom_mem[rom_address1];
    q3_a   <= rom_mem[rom_address3];
    q3_b   <= q3_a;
    rom_q3 <= q3_b;
  end

  // Model: ROM address of the texel under (dx,dy), or -1 when not a hit.
  function automatic int model_texel(input int dx, input int dy, input logic en,
                                     input logic flp, input int px, input int py,
                                     input int frm);
    int tx, ty;
    if (!en || dx < px || dx >= px + IMG_W * SCALE ||
        dy < py || dy >= py + IMG_H * SCALE) return -1;
    tx = (dx - px) / SCALE;
    ty = (dy - py) / SCALE;
    if (flp) tx = IMG_W - 1 - tx;
    return frm * IMG_W * IMG_H + ty * IMG_W + tx;
  endfunction

  function automatic logic [11:0] model_pixel(input int dx, input int dy,
                                              input logic blk, input logic en,
                                              input logic flp, input int px,
                                              input int py, input logic [11:0] bg,
                                              input int frm);
    int a;
    if (!blk) return 12'h000;
    a = model_texel(dx, dy, en, flp, px, py, frm);
    if (a >= 0 && rom_mem[a] != 4'd0) return pal_color(rom_mem[a]);
    return bg;
  endfunction

  // Expected-colour delay lines and animation state of the model.
  logic [11:0] exp1 [2];
  logic [11:0] exp3 [4];
  int m_frame, m_hold;

  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) exp1[i] <= '0;
      for (int i = 0; i < 4; i++) exp3[i] <= '0;
      m_frame <= 0;
      m_hold  <= 0;
    end else begin
      exp1[0] <= model_pixel(int'(DrawX), int'(DrawY), blank, enable, flip_x,
                             int'(pos_x), int'(pos_y), {bg_red, bg_green, bg_blue}, m_frame);
      exp1[1] <= exp1[0];
      exp3[0] <= model_pixel(int'(DrawX), int'(DrawY), blank, enable, flip_x,
                             int'(pos_x), int'(pos_y), {bg_red, bg_green, bg_blue}, m_frame);
      for (int i = 1; i < 4; i++) exp3[i] <= exp3[i-1];
      if (vsync_pulse && anim_en) begin
        if (m_hold == HOLD - 1) begin
          m_hold  <= 0;
          m_frame <= (m_frame + 1) % NFR;
        end else begin
          m_hold <= m_hold + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge vga_clk) begin
    if (check_en) begin
      int a;
      a = model_texel(int'(DrawX), int'(DrawY), enable, flip_x,
                      int'(pos_x), int'(pos_y), m_frame);
      if (a < 0) a = 0;
      checkOutput("rgb_lat1", 16'({red1, green1, blue1}), 16'(exp1[1]));
      checkOutput("rgb_lat3", 16'({red3, green3, blue3}), 16'(exp3[3]));
      checkOutput("frame_lat1", 16'(frame_idx1), 16'(m_frame));
      checkOutput("frame_lat3", 16'(frame_idx3), 16'(m_frame));
      checkOutput("addr_lat1", 16'(rom_address1), 16'(a));
      checkOutput("addr_lat3", 16'(rom_address3), 16'(a));
      checkOutput("pal_index1", 16'(pal_index1), 16'(rom_q1));
      checkOutput("pal_index3", 16'(pal_index3), 16'(rom_q3));
    end
  end

  task automatic applyStimulus(input int x, input int y, input logic blk,
                               input logic vs);
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    blank       = blk;
    vsync_pulse = vs;
    @(posedge vga_clk);
    #1;
    vsync_pulse = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(int'(DrawX), int'(DrawY), blank, 1'b1);
      applyStimulus(int'(DrawX), int'(DrawY), blank, 1'b0);
    end
  endtask

  initial begin
    // Frames 0 and 2 are index 5 (red), frame 1 index 7 (green), frame 3 index 9.
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = (i < 1024) ? 4'd5 : (i < 2048) ? 4'd7 : (i < 3072) ? 4'd5 : 4'd9;

    // Reset state and release: black for one edge, then background.
    repeat (3) @(posedge vga_clk);
    #1;
    check_en = 1'b1;
    checkOutput("reset_rgb", 16'({red1, green1, blue1}), 16'h000);
    checkOutput("reset_frame", 16'(frame_idx1), 16'h0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 1'b1, 1'b0);
    checkOutput("release_edge1", 16'({red1, green1, blue1}), 16'h000);
    applyStimulus(0, 0, 1'b1, 1'b0);
    checkOutput("release_edge2", 16'({red1, green1, blue1}), 16'h008);

    // Sweep row 60 across the sprite at (100,50).
    for (int x = 98; x <= 170; x++) begin
      applyStimulus(x, 60, 1'b1, 1'b0);
      if (x == 100) checkOutput("s1_px99",  16'({red1, green1, blue1}), 16'h008);
      if (x == 101) checkOutput("s1_px100", 16'({red1, green1, blue1}), 16'hF00);
      if (x == 164) checkOutput("s1_px163", 16'({red1, green1, blue1}), 16'hF00);
      if (x == 165) checkOutput("s1_px164", 16'({red1, green1, blue1}), 16'h008);
      if (x == 102) checkOutput("s1_l3_px99",  16'({red3, green3, blue3}), 16'h008);
      if (x == 103) checkOutput("s1_l3_px100", 16'({red3, green3, blue3}), 16'hF00);
      if (x == 167) checkOutput("s1_l3_px164", 16'({red3, green3, blue3}), 16'h008);
    end

    // Transparent texel 0, then mirrored.
    rom_mem[0] = 4'd0;
    for (int x = 99; x <= 104; x++) begin
      applyStimulus(x, 50, 1'b1, 1'b0);
      if (x == 101) checkOutput("tr_px100", 16'({red1, green1, blue1}), 16'h008);
      if (x == 102) checkOutput("tr_px101", 16'({red1, green1, blue1}), 16'h008);
      if (x == 103) checkOutput("tr_px102", 16'({red1, green1, blue1}), 16'hF00);
    end
    flip_x = 1'b1;
    for (int x = 100; x <= 166; x++) begin
      applyStimulus(x, 50, 1'b1, 1'b0);
      if (x == 101) checkOutput("fl_px100", 16'({red1, green1, blue1}), 16'hF00);
      if (x == 162) checkOutput("fl_px161", 16'({red1, green1, blue1}), 16'hF00);
      if (x == 163) checkOutput("fl_px162", 16'({red1, green1, blue1}), 16'h008);
      if (x == 164) checkOutput("fl_px163", 16'({red1, green1, blue1}), 16'h008);
    end
    flip_x = 1'b0;
    applyStimulus(0, 0, 1'b0, 1'b0);
    rom_mem[0] = 4'd5;

    // Animation with the sprite visible at its top-left texel.
    anim_en = 1'b1;
    applyStimulus(100, 50, 1'b1, 1'b0);
    pulses(8);
    checkOutput("anim_frame1", 16'(frame_idx1), 16'h1);
    checkOutput("anim_addr1024", 16'(rom_address1), 16'd1024);
    applyStimulus(100, 50, 1'b1, 1'b0);
    checkOutput("anim_green", 16'({red1, green1, blue1}), 16'h0F0);
    pulses(24);
    checkOutput("anim_wrap", 16'(frame_idx1), 16'h0);
    pulses(3);
    anim_en = 1'b0;
    pulses(10);
    checkOutput("anim_frozen", 16'(frame_idx1), 16'h0);
    anim_en = 1'b1;
    pulses(4);
    checkOutput("anim_hold_kept", 16'(frame_idx1), 16'h0);
    pulses(1);
    checkOutput("anim_resume", 16'(frame_idx1), 16'h1);
    pulses(8);
    checkOutput("anim_frame2", 16'(frame_idx1), 16'h2);
    anim_en = 1'b0;

    // Reset mid-line while frame 2 is showing.
    for (int x = 100; x <= 110; x++) applyStimulus(x, 60, 1'b1, 1'b0);
    checkOutput("pre_reset_red", 16'({red1, green1, blue1}), 16'hF00);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_rgb1", 16'({red1, green1, blue1}), 16'h000);
    checkOutput("midreset_rgb3", 16'({red3, green3, blue3}), 16'h000);
    checkOutput("midreset_frame", 16'(frame_idx1), 16'h0);
    repeat (3) applyStimulus(111, 60, 1'b1, 1'b0);
    reset_n = 1'b1;
    applyStimulus(112, 60, 1'b1, 1'b0);
    checkOutput("rel_mid_edge1", 16'({red1, green1, blue1}), 16'h000);
    applyStimulus(113, 60, 1'b1, 1'b0);
    checkOutput("rel_mid_edge2", 16'({red1, green1, blue1}), 16'hF00);

    // Right-edge clipping: sprite at column 620 must not wrap to column 0.
    pos_x = 10'd620;
    for (int x = 612; x <= 639; x++) applyStimulus(x, 60, 1'b1, 1'b0);
    for (int x = 0; x <= 50; x++) begin
      applyStimulus(x, 60, 1'b1, 1'b0);
      if (x == 0) begin
        checkOutput("clip_px639", 16'({red1, green1, blue1}), 16'hF00);
        checkOutput("clip_addr0", 16'(rom_address1), 16'h000);
      end
      if (x == 2)  checkOutput("clip_px1",  16'({red1, green1, blue1}), 16'h008);
      if (x == 44) checkOutput("clip_px43", 16'({red1, green1, blue1}), 16'h008);
    end
    applyStimulus(630, 60, 1'b0, 1'b0);
    applyStimulus(631, 60, 1'b0, 1'b0);
    checkOutput("blank_hit", 16'({red1, green1, blue1}), 16'h000);
    repeat (5) applyStimulus(0, 0, 1'b0, 1'b0);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_layer.md
# sprite_layer

Parametrised, pipelined sprite renderer for the VGA pixel path. For each pixel it tests whether the current (DrawX, DrawY) lies inside a positioned, integer-scaled, optionally mirrored sprite. On a hit it fetches a palette index from an external sprite ROM, resolves transparency against an incoming background colour, and registers the 12-bit result. It adds multi-frame animation advanced on vertical sync. Instances chain layer-on-layer: background → terrain → enemies → Link.

## Interface
Parameters:
- IMG_W, 32, sprite width in texels (power of two)
- IMG_H, 32, sprite height in texels (power of two)
- SCALE_LOG2, 1, on-screen scale = 2^SCALE_LOG2 pixels per texel, both axes
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM
- FRAME_HOLD, 8, vsync pulses each frame is shown (≥1)
- ROM_LATENCY, 1, cycles from rom_address to valid rom_q (≥1)
- PAL_BITS, 4, palette index width
- TRANSPARENT_IDX, 0, palette index treated as see-through

Ports:
- vga_clk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video (same sense as the VGA controller)
- vsync_pulse  in  1  one-cycle pulse per frame, issued during vertical blanking
- enable  in  1  0 = sprite never hits
- anim_en  in  1  1 = animation counter runs
- flip_x  in  1  mirror sprite horizontally
- pos_x, pos_y  in  10 each  screen coordinate of the sprite's top-left pixel
- bg_red, bg_green, bg_blue  in  4 each  background colour for this pixel, aligned with DrawX
- rom_address  out  AW = clog2(IMG_W·IMG_H·NUM_FRAMES)  sprite ROM address
- rom_q  in  PAL_BITS  ROM data, ROM_LATENCY cycles after address
- pal_index  out  PAL_BITS  palette index, equal to rom_q
- pal_red, pal_green, pal_blue  in  4 each  combinational palette output for pal_index
- red, green, blue  out  4 each  registered pixel colour
- frame_idx  out  clog2(NUM_FRAMES)  current animation frame

## Operation
- Address stage (combinational from inputs, 11-bit arithmetic, no wrap):
  - SW = IMG_W<<SCALE_LOG2; SH = IMG_H<<SCALE_LOG2.
  - hit = enable ∧ pos_x ≤ DrawX < pos_x+SW ∧ pos_y ≤ DrawY < pos_y+SH.
  - lx = (DrawX−pos_x)>>SCALE_LOG2; if flip_x then lx = IMG_W−1−lx. ly = (DrawY−pos_y)>>SCALE_LOG2.
  - rom_address = frame_idx·IMG_W·IMG_H + ly·IMG_W + lx when hit, else 0.
  - A sprite extending past column 639 or row 479 is clipped, not wrapped.
- Side-band pipeline: hit, blank, bg_* are delayed ROM_LATENCY registers so they align with rom_q.
- Colour select, at the output register:
  - delayed blank = 0 → red/green/blue = 0.
  - Otherwise delayed hit ∧ rom_q ≠ TRANSPARENT_IDX → pal_*.
  - Otherwise → delayed bg_*.
- Animation:
  - hold_cnt counts vsync_pulse while anim_en = 1.
  - When vsync_pulse arrives with hold_cnt = FRAME_HOLD−1, hold_cnt returns to 0 and frame_idx increments, wrapping NUM_FRAMES−1 → 0.
  - anim_en = 0 freezes both hold_cnt and frame_idx; it does not reset them.
  - frame_idx changes only on vsync_pulse, so a visible frame never tears.

## Timing
- Pixel latency is ROM_LATENCY+1 edges: inputs sampled in cycle t appear on red/green/blue after edge t+ROM_LATENCY+1.
- With the defaults the latency is 2 cycles. The VGA controller's hs/vs must be delayed to match.
- pal_index/rom_q is valid ROM_LATENCY cycles after its address.
- frame_idx updates on the edge that samples vsync_pulse. Addresses in the following cycle use the new value.
- Reset (asynchronous assert, synchronous release):
  - red/green/blue = 0, frame_idx = 0, hold_cnt = 0.
  - All pipeline registers are cleared; delayed blank = 0 and delayed hit = 0.
  - Output is black until ROM_LATENCY+1 edges after release.
  - Reset mid-line discards in-flight pixels; there is no partial-pixel output.
- Simultaneous vsync_pulse and anim_en falling in the same cycle: the pulse is sampled with anim_en = 0, so nothing advances.

## Test plan
- Defaults, pos = (100,50), ROM all index 5, palette 5 = (F,0,0), bg = (0,0,8), blank = 1. Sweep DrawX 98..166 on DrawY 60 → red = F exactly for DrawX 100..163, 2 cycles late; (0,0,8) elsewhere.
- ROM texel 0 = TRANSPARENT_IDX, rest = 5; DrawX 100,101 at DrawY 50 → bg passes through. DrawX 102 → F,0,0. flip_x = 1 → texel 0 appears at DrawX 162,163.
- anim_en = 1, FRAME_HOLD = 8: 8 vsync pulses → frame_idx 0→1 and rom_address offset becomes 1024. 32 pulses → wraps to 0. Drop anim_en after 3 pulses → frame_idx and hold_cnt hold.
- pos_x = 620 (64-pixel sprite): DrawX 620..639 hit, no hit at DrawX 0..43 on the same row (no wrap). blank = 0 during a hit → output 0.
- Assert reset_n = 0 mid-line with frame_idx = 2 → all outputs 0 immediately and frame_idx = 0. After release, first non-zero colour appears no earlier than 2 edges.
- ROM_LATENCY = 3 instance → same colour sequence as scenario 1, shifted to 4-cycle latency, with bg and hit edges aligned exactly.
